// File: rtl/vlg_gray_decoder_pkg.sv
// Shared Gray-code definitions: decoder FSM state encodings and a reference gray2bin function.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package gray_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  // Gray -> binary on a 32-bit word; zero-extended narrower words decode correctly
  // because the zero upper bits contribute nothing to the prefix XOR.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray -> binary converter, WIDTH-parameterised prefix XOR.
// Latency: 0 clk (pure combinational).
// Backpressure: none.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/vlg_gray_decoder.sv
// Gray-coded stream -> binary, with up/down/hold direction and multi-step jump detection.
// Latency: 2 clk from i_valid to o_valid, one sample per clock.
// Backpressure: none; i_clr and i_rst drop in-flight samples.
module vlg_gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_gray,
  input  logic                 i_clr,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_bin,
  output logic                 o_up,
  output logic                 o_dn,
  output logic                 o_step_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [WIDTH-1:0]     DELTA_UP = 1;
  localparam logic [WIDTH-1:0]     DELTA_DN = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_gray;
  logic [WIDTH-1:0] r_prev;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  logic             w_up;
  logic             w_dn;
  logic             w_err;

  // Stage 1: capture the raw sample; clear/reset drop it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_gray <= '0;
    end else begin
      r_s1_vld  <= i_valid & ~i_clr;
      r_s1_gray <= i_gray;
    end
  end

  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .i_gray (r_s1_gray),
    .o_bin  (w_bin)
  );

  assign w_delta = w_bin - r_prev;

  // Next state and step classification; only a valid stage-1 sample advances the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_up        = 1'b0;
    w_dn        = 1'b0;
    w_err       = 1'b0;
    if (r_s1_vld) begin
      case (r_state)
        S_TRACK: begin
          if (w_delta == DELTA_UP) begin
            w_up = 1'b1;
          end else if (w_delta == DELTA_DN) begin
            w_dn = 1'b1;
          end else if (w_delta != '0) begin
            w_err = 1'b1;
          end
          w_state_nxt = w_err ? S_RESYNC : S_TRACK;
        end
        default: w_state_nxt = S_TRACK;  // S_IDLE / S_RESYNC: emit unchecked, take reference
      endcase
    end
  end

  // FSM state register; reset and clear both drop the reference.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage 2: registered outputs, reference value and saturating error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_bin      <= '0;
      o_up       <= 1'b0;
      o_dn       <= 1'b0;
      o_step_err <= 1'b0;
      o_err_cnt  <= '0;
      r_prev     <= '0;
    end else if (i_clr) begin
      // o_bin and r_prev kept: clear only forgets tracking, not the last value seen.
      o_valid    <= 1'b0;
      o_up       <= 1'b0;
      o_dn       <= 1'b0;
      o_step_err <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_valid    <= r_s1_vld;
      o_up       <= w_up;
      o_dn       <= w_dn;
      o_step_err <= w_err;
      if (r_s1_vld) begin
        o_bin  <= w_bin;
        r_prev <= w_bin;
      end
      if (w_err && (o_err_cnt != CNT_MAX)) begin
        o_err_cnt <= o_err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_vlg_gray_decoder.sv
// Directed bench for vlg_gray_decoder: two instances (8-bit and 2-bit error counter) share stimulus.
// Latency: outputs for a sample are checked one step after the step that sees it in stage 1.
// Backpressure: none exercised (design has none).
module tb_vlg_gray_decoder;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic [3:0] i_gray;
  logic       i_clr;

  logic       o8_valid, o8_up, o8_dn, o8_err;
  logic [3:0] o8_bin;
  logic [7:0] o8_cnt;
  logic       o2_valid, o2_up, o2_dn, o2_err;
  logic [3:0] o2_bin;
  logic [1:0] o2_cnt;

  int total = 0;
  int bad   = 0;

  vlg_gray_decoder #(.WIDTH(4), .ERR_CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_gray(i_gray), .i_clr(i_clr),
    .o_valid(o8_valid), .o_bin(o8_bin), .o_up(o8_up), .o_dn(o8_dn),
    .o_step_err(o8_err), .o_err_cnt(o8_cnt)
  );

  vlg_gray_decoder #(.WIDTH(4), .ERR_CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_gray(i_gray), .i_clr(i_clr),
    .o_valid(o2_valid), .o_bin(o2_bin), .o_up(o2_up), .o_dn(o2_dn),
    .o_step_err(o2_err), .o_err_cnt(o2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [3:0] eb,
                         input logic eu, input logic ed, input logic ee, input int ec);
    chk({tag, ".vld"}, {31'd0, o8_valid}, {31'd0, ev});
    chk({tag, ".bin"}, {28'd0, o8_bin}, {28'd0, eb});
    chk({tag, ".up"},  {31'd0, o8_up},  {31'd0, eu});
    chk({tag, ".dn"},  {31'd0, o8_dn},  {31'd0, ed});
    chk({tag, ".err"}, {31'd0, o8_err}, {31'd0, ee});
    chk({tag, ".cnt8"}, {24'd0, o8_cnt}, ec);
    chk({tag, ".cnt2"}, {30'd0, o2_cnt}, (ec < 3) ? ec : 3);
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic v, input logic [3:0] g, input logic c, input logic r);
    i_valid = v;
    i_gray  = g;
    i_clr   = c;
    i_rst   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_gray = 4'd0; i_clr = 1'b0;

    // Reset state
    step(0, 4'b0000, 0, 1);
    step(0, 4'b0000, 0, 1);
    chk_out("rst", 0, 4'd0, 0, 0, 0, 0);

    // 1. Counting up 0..4
    step(1, 4'b0000, 0, 0);
    chk_out("up.pre", 0, 4'd0, 0, 0, 0, 0);
    step(1, 4'b0001, 0, 0);
    chk_out("up.s0", 1, 4'd0, 0, 0, 0, 0);
    step(1, 4'b0011, 0, 0);
    chk_out("up.s1", 1, 4'd1, 1, 0, 0, 0);
    step(1, 4'b0010, 0, 0);
    chk_out("up.s2", 1, 4'd2, 1, 0, 0, 0);
    step(1, 4'b0110, 0, 0);
    chk_out("up.s3", 1, 4'd3, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("up.s4", 1, 4'd4, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("up.hold", 0, 4'd4, 0, 0, 0, 0);

    // 2. Wrap up and down: 15 -> 0 -> 15 (clear first to drop reference 4)
    step(0, 4'b0000, 1, 0);
    step(1, 4'b1000, 0, 0);
    step(1, 4'b0000, 0, 0);
    chk_out("wrap.15", 1, 4'd15, 0, 0, 0, 0);
    step(1, 4'b1000, 0, 0);
    chk_out("wrap.up0", 1, 4'd0, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("wrap.dn15", 1, 4'd15, 0, 1, 0, 0);

    // 3. Jump 0 -> 4 flags error, 5 unchecked, 6 up
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0110, 0, 0);
    chk_out("jmp.0", 1, 4'd0, 1, 0, 0, 0);
    step(1, 4'b0111, 0, 0);
    chk_out("jmp.4", 1, 4'd4, 0, 0, 1, 1);
    step(1, 4'b0101, 0, 0);
    chk_out("jmp.5", 1, 4'd5, 0, 0, 0, 1);
    step(0, 4'b0000, 0, 0);
    chk_out("jmp.6", 1, 4'd6, 1, 0, 0, 1);

    // 4. Saturation: alternate 0/4 for 12 samples after a clear
    step(0, 4'b0000, 1, 0);
    chk_out("sat.clr", 0, 4'd6, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      step(1, (j % 2 == 0) ? 4'b0000 : 4'b0110, 0, 0);
      if (j > 0) begin
        chk_out("sat", 1, ((j - 1) % 2 == 0) ? 4'd0 : 4'd4, 0, 0,
                ((j - 1) % 2 == 1), j / 2);
      end
    end
    step(0, 4'b0000, 0, 0);
    chk_out("sat.last", 1, 4'd4, 0, 0, 1, 6);

    // 5. Clear one clk after i_valid drops the sample; next sample unchecked
    step(1, 4'b0011, 0, 0);
    step(0, 4'b0000, 1, 0);
    chk_out("clr.drop", 0, 4'd4, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("clr.drop2", 0, 4'd4, 0, 0, 0, 0);
    step(1, 4'b0110, 0, 0);
    step(1, 4'b0111, 0, 0);
    chk_out("clr.idle", 1, 4'd4, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("clr.track", 1, 4'd5, 1, 0, 0, 0);

    // 6. Reset between i_valid and o_valid
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0001, 0, 0);
    chk_out("rst.err", 1, 4'd0, 0, 0, 1, 1);
    step(0, 4'b0000, 0, 1);
    chk_out("rst.mid", 0, 4'd0, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("rst.after", 0, 4'd0, 0, 0, 0, 0);
    step(1, 4'b0011, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk_out("rst.first", 1, 4'd2, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
